// File: rtl/pipe_adder.sv
// Pipelined ripple-block adder: {cout, s} = a + b + cin, one CW-bit chunk per stage, latency STAGES.
// Optional golden-model self-check is built when PIPE_ADDER_SELF_CHECK_EN is defined; otherwise err is 0.
module pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             valid_in,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             valid_out,
    output logic             err
);

    localparam int SAFE_STAGES = (STAGES < 1) ? 1 : STAGES;
    localparam int CW          = WIDTH / SAFE_STAGES;

    generate
        if ((STAGES < 1) || ((WIDTH % SAFE_STAGES) != 0)) begin : bad_param_g
            $error("pipe_adder: STAGES must be >= 1 and divide WIDTH");
        end
    endgenerate

    // Stage gi consumes operand chunk gi; the operand bits above it travel on in
    // narrowing skew registers, and the finished low chunks accumulate in sum_reg.
    for (genvar gi = 0; gi < STAGES; gi++) begin : stage_g
        localparam int LO  = gi * CW;
        localparam int REM = WIDTH - LO;

        logic [REM-1:0]     a_in;
        logic [REM-1:0]     b_in;
        logic               carry_in;
        logic               v_in;
        logic [CW:0]        chunk_sum;
        logic [LO+CW-1:0]   sum_next;
        logic [LO+CW-1:0]   sum_reg;
        logic               carry_reg;
        logic               valid_reg;

        assign chunk_sum = {1'b0, a_in[CW-1:0]} + {1'b0, b_in[CW-1:0]} + {{CW{1'b0}}, carry_in};

        if (gi == 0) begin : src_g
            assign a_in     = a;
            assign b_in     = b;
            assign carry_in = cin;
            assign v_in     = valid_in;
            assign sum_next = chunk_sum[CW-1:0];
        end else begin : src_g
            assign a_in     = stage_g[gi-1].skew_g.a_skew_reg;
            assign b_in     = stage_g[gi-1].skew_g.b_skew_reg;
            assign carry_in = stage_g[gi-1].carry_reg;
            assign v_in     = stage_g[gi-1].valid_reg;
            assign sum_next = {chunk_sum[CW-1:0], stage_g[gi-1].sum_reg};
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_reg <= 1'b0;
                sum_reg   <= '0;
                carry_reg <= 1'b0;
            end else begin
                valid_reg <= v_in;
                if (v_in) begin
                    sum_reg   <= sum_next;
                    carry_reg <= chunk_sum[CW];
                end
            end
        end

        if (gi < STAGES - 1) begin : skew_g
            logic [REM-CW-1:0] a_skew_reg;
            logic [REM-CW-1:0] b_skew_reg;

            always_ff @(posedge clk) begin
                if (v_in) begin
                    a_skew_reg <= a_in[REM-1:CW];
                    b_skew_reg <= b_in[REM-1:CW];
                end
            end
        end
    end

    assign s         = stage_g[STAGES-1].sum_reg;
    assign cout      = stage_g[STAGES-1].carry_reg;
    assign valid_out = stage_g[STAGES-1].valid_reg;

`ifdef PIPE_ADDER_SELF_CHECK_EN
    // Golden full-width result rides alongside the chunked pipeline with the same enables.
    logic [WIDTH:0] gold_reg [STAGES];
    logic           err_reg;

    for (genvar gi = 0; gi < STAGES; gi++) begin : gold_g
        if (gi == 0) begin : first_g
            always_ff @(posedge clk) begin
                if (valid_in) begin
                    gold_reg[0] <= {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
                end
            end
        end else begin : next_g
            always_ff @(posedge clk) begin
                if (stage_g[gi-1].valid_reg) begin
                    gold_reg[gi] <= gold_reg[gi-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if (valid_out && (gold_reg[STAGES-1] != {cout, s})) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Testbench for pipe_adder: table vectors, bubble/reset sequences and a random stream,
// all checked in order against a scoreboard queue with exact-latency checking.
module tb_pipe_adder;
    localparam int WIDTH  = 32;
    parameter  int STAGES = 4;
    localparam int RST_T  = (STAGES >= 3) ? 2 : 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             valid_in = 1'b0;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             valid_out;
    logic             err;

    pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .valid_in(valid_in),
        .s(s), .cout(cout), .valid_out(valid_out), .err(err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             cout;
        int unsigned      cyc;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [WIDTH-1:0] s;
        logic             cout;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle of inputs on the falling edge; optionally record the expected result.
    task automatic drive(input logic v, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic cv, input logic [WIDTH-1:0] es, input logic ec, input bit push);
        exp_t e;
        @(negedge clk);
        valid_in = v;
        a        = av;
        b        = bv;
        cin      = cv;
        if (push && v && !rst) begin
            e.s    = es;
            e.cout = ec;
            e.cyc  = cyc;
            sb_q.push_back(e);
        end
    endtask

    task automatic drive_model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv);
        logic [WIDTH:0] sum;
        sum = {1'b0, av} + {1'b0, bv} + {{WIDTH{1'b0}}, cv};
        drive(1'b1, av, bv, cv, sum[WIDTH-1:0], sum[WIDTH], 1'b1);
    endtask

    task automatic idle();
        drive(1'b0, $urandom, $urandom, 1'($urandom), '0, 1'b0, 1'b0);
    endtask

    // Scoreboard monitor: every valid_out must match the oldest pending result, with exact latency.
    always @(negedge clk) begin
        if (valid_out) begin
            if (sb_q.size() == 0) begin
                check("unexpected_valid_out", 64'(valid_out), 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                $display("result cycle %0d: s=0x%08h cout=%0d (expect s=0x%08h cout=%0d)",
                         cyc, s, cout, e.s, e.cout);
                check("sum", 64'(s), 64'(e.s));
                check("cout", 64'(cout), 64'(e.cout));
                check("latency", 64'(cyc - e.cyc), 64'(STAGES));
            end
        end
    end

    vec_t vecs[10];

    initial begin
        vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
        vecs[2] = '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 32'h0100_0000, 1'b0};
        vecs[3] = '{32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0};
        vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
        vecs[5] = '{32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_000B, 1'b0};
        vecs[6] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
        vecs[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
        vecs[8] = '{32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0};
        vecs[9] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0};

        // Reset state, with valid_in held high during reset (must be ignored).
        valid_in = 1'b1;
        repeat (3) @(negedge clk);
        rst      = 1'b0;
        valid_in = 1'b0;
        check("reset_s", 64'(s), 64'd0);
        check("reset_cout", 64'(cout), 64'd0);
        check("reset_valid_out", 64'(valid_out), 64'd0);
        check("reset_err", 64'(err), 64'd0);

        // Table vectors back to back.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].cout, 1'b1);
        end
        repeat (STAGES + 2) idle();

        // Bubbles: valid pattern 1,0,1; output must hold 30 through the bubble.
        for (int t = 0; t < STAGES + 3; t++) begin
            if (t == 0)      drive(1'b1, 32'd10, 32'd20, 1'b0, 32'd30, 1'b0, 1'b1);
            else if (t == 2) drive(1'b1, 32'd7, 32'd8, 1'b1, 32'd16, 1'b0, 1'b1);
            else             idle();
            if (t == STAGES) begin
                check("bubble_v0", 64'(valid_out), 64'd1);
                check("bubble_s0", 64'(s), 64'd30);
            end else if (t == STAGES + 1) begin
                check("bubble_v1", 64'(valid_out), 64'd0);
                check("bubble_hold", 64'(s), 64'd30);
            end else if (t == STAGES + 2) begin
                check("bubble_v2", 64'(valid_out), 64'd1);
                check("bubble_s2", 64'(s), 64'd16);
            end
        end
        repeat (2) idle();

        // Reset mid-flight: both operations must vanish.
        drive(1'b1, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, '0, 1'b0, 1'b0);
        drive(1'b1, 32'h0000_0003, 32'h0000_0004, 1'b0, '0, 1'b0, 1'b0);
        if (RST_T == 2) idle();
        @(negedge clk);
        rst      = 1'b1;
        valid_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_s", 64'(s), 64'd0);
        check("midrst_cout", 64'(cout), 64'd0);
        check("midrst_err", 64'(err), 64'd0);
        for (int t = 0; t < STAGES + 2; t++) begin
            idle();
            check("midrst_no_valid", 64'(valid_out), 64'd0);
        end

        // Fresh operation after reset completes normally.
        drive_model(32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0);
        repeat (STAGES + 2) idle();

        // Random back-to-back stream.
        for (int i = 0; i < 1000; i++) begin
            drive_model($urandom, $urandom, 1'($urandom));
        end
        begin
            int waited;
            waited = 0;
            while (sb_q.size() != 0 && waited < 100) begin
                idle();
                waited++;
            end
        end
        check("drain_empty", 64'(sb_q.size()), 64'd0);
        check("final_err", 64'(err), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pipe_adder.md
# pipe_adder

Pipelined ripple-block adder that sits on the DUT side of the adder test harness. It samples operand pairs and a carry-in under `valid_in`, and returns `{cout, s}` with a matching `valid_out` a fixed number of cycles later. The carry chain is split into `STAGES` equal chunks, one chunk per pipeline stage, so the critical path is one chunk add. The block accepts one operation per cycle and has no backpressure; the consumer is always ready.

## Interface
- `WIDTH`, 32, operand/sum width in bits.
- `STAGES`, 4, number of pipeline stages.
  - Must be ≥1.
  - `WIDTH % STAGES == 0`; elaboration fails otherwise.
  - Chunk width is `CW = WIDTH/STAGES`.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `a`  in  WIDTH  operand A, sampled when `valid_in`=1.
- `b`  in  WIDTH  operand B, sampled when `valid_in`=1.
- `cin`  in  1  carry-in, sampled when `valid_in`=1.
- `valid_in`  in  1  operand-valid strobe; one operation per high cycle.
- `s`  out  WIDTH  sum, registered.
- `cout`  out  1  carry-out, registered.
- `valid_out`  out  1  result-valid strobe; high for exactly one cycle per accepted operation.
- `err`  out  1  sticky self-check mismatch flag (see Configuration).

## Operation
**Stage structure**
- Stage k (0..STAGES-1) adds chunk k of `a` and `b`, bits `[k*CW +: CW]`.
- Stage 0 uses `cin` as its carry-in. Stage k>0 uses the registered carry from stage k-1.
- Operand chunks above k are carried forward in skew registers.
- Result chunks below k are carried forward in deskew registers.
- The final stage drives `s` and `cout` directly from registers.

**Valid pipeline**
- Each stage has one valid bit, shifted every cycle.
- Stage data registers load only when the valid bit entering that stage is 1; otherwise they hold.
- Consequence: `s`/`cout` hold the last valid result through bubbles.

**Arithmetic**
- `{cout, s} = a + b + cin`, modulo 2^(WIDTH+1).
- No overflow flag and no signed interpretation.

**Flow control**
- No stall input and no internal buffering beyond the pipeline.
- Back-to-back `valid_in` produces back-to-back `valid_out`, in order.

**Reset**
- All valid bits clear, `s`=0, `cout`=0, `valid_out`=0, `err`=0.
- Skew/deskew data registers need not reset.
- Reset asserted mid-flight discards every in-flight operation; no `valid_out` pulse is ever produced for it.
- `valid_in` sampled in the same cycle as `rst`=1 is ignored.

## Timing
- Latency: operation sampled at edge N (`valid_in`=1) produces `valid_out`=1 with its result during the cycle after edge N+STAGES-1, i.e. STAGES cycles from `valid_in` to `valid_out`.
- STAGES=1 degenerates to a single registered full adder with latency 1.
- Throughput: 1 operation/cycle, sustained indefinitely.
- `valid_out` is a pure delayed copy of `valid_in`, gated by reset; there is no combinational path from input to output.
- First cycle after `rst` deasserts:
  - `valid_in` is accepted normally.
  - `valid_out` stays 0 for at least STAGES cycles.

## Configuration
Macro: `PIPE_ADDER_SELF_CHECK_EN`.

**Defined**
- A golden `{cout,s}` is computed as a single-cycle full-width add at the input.
- It is delayed through its own STAGES-deep register line, enabled identically to the valid pipeline.
- It is compared against `{cout, s}` in every cycle where `valid_out`=1.
- Any mismatch sets `err` on the next edge; `err` stays set until `rst`.
- Latency and throughput are unchanged.

**Undefined**
- Golden path and comparator are not built; `err` is tied to 0.
- Functional behaviour of `s`/`cout`/`valid_out` is identical to the defined case.

## Test plan
Defaults assumed: WIDTH=32, STAGES=4.
- Full carry ripple: a=0xFFFFFFFF, b=0x00000001, cin=0 → 4 cycles later `valid_out`=1, s=0x00000000, cout=1.
- Carry-in only: a=0xFFFFFFFF, b=0x00000000, cin=1 → s=0x00000000, cout=1. Also a=0x00FFFFFF, b=1, cin=0 → s=0x01000000, cout=0.
- Back-to-back stream: (1,2,0), (0x80000000,0x80000000,0), (5,5,1) on consecutive cycles → three consecutive `valid_out` cycles with s=3/cout=0, s=0/cout=1, s=11/cout=0.
- Bubbles: `valid_in` pattern 1,0,1 with (10,20,0), (x), (7,8,1):
  - `valid_out` pattern is 1,0,1.
  - s=30, then holds 30 during the bubble, then 16.
- Reset mid-flight: two operations issued, `rst` pulsed for 1 cycle two cycles later → `valid_out` never rises for either, s=0, cout=0, `err`=0. A fresh operation after reset completes normally in 4 cycles.
- Self-check, macro defined: 1000 random back-to-back vectors, also run with STAGES=1 and STAGES=8 → `err` stays 0, and every result matches the scoreboard in order.
